// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops and iterative
// one-bit-per-cycle shifts and rotates behind a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             c_flag,
    output logic             v_flag,
    output logic             z_flag,
    output logic             n_flag,
    output logic             err
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       opReg;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [SHW-1:0]   cnt;
    logic             carry;

    logic [WIDTH-1:0] bOp;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             msbCarryIn;
    logic [WIDTH-1:0] execR;
    logic             execC;
    logic             execV;
    logic             execErr;
    logic [WIDTH-1:0] shNext;
    logic             shOut;
    logic             isShiftOp;

    assign isShiftOp = (op == OP_SHL) || (op == OP_SHR)
                    || (op == OP_ROL) || (op == OP_ROR);

    // SUB reuses the adder as a + ~b + 1
    always_comb begin
        cin        = (opReg == OP_SUB);
        bOp        = cin ? ~bReg : bReg;
        sum        = {1'b0, aReg} + {1'b0, bOp} + (WIDTH + 1)'(cin);
        msbCarryIn = aReg[WIDTH-1] ^ bOp[WIDTH-1] ^ sum[WIDTH-1];
    end

    always_comb begin
        execR   = '0;
        execC   = 1'b0;
        execV   = 1'b0;
        execErr = 1'b0;
        case (opReg)
            OP_ADD, OP_SUB: begin
                execR = sum[WIDTH-1:0];
                execC = sum[WIDTH];
                execV = msbCarryIn ^ sum[WIDTH];
            end
            OP_XOR: execR = aReg ^ bReg;
            OP_AND: execR = aReg & bReg;
            OP_OR:  execR = aReg | bReg;
            OP_NOR: execR = ~(aReg | bReg);
            default: execErr = 1'b1;
        endcase
    end

    // One bit position per cycle; shOut is the bit leaving the word
    always_comb begin
        shNext = aReg;
        shOut  = 1'b0;
        case (opReg)
            OP_SHL: begin
                shNext = {aReg[WIDTH-2:0], 1'b0};
                shOut  = aReg[WIDTH-1];
            end
            OP_SHR: begin
                shNext = {1'b0, aReg[WIDTH-1:1]};
                shOut  = aReg[0];
            end
            OP_ROL: begin
                shNext = {aReg[WIDTH-2:0], aReg[WIDTH-1]};
                shOut  = aReg[WIDTH-1];
            end
            OP_ROR: begin
                shNext = {aReg[0], aReg[WIDTH-1:1]};
                shOut  = aReg[0];
            end
            default: begin
                shNext = aReg;
                shOut  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            opReg  <= '0;
            aReg   <= '0;
            bReg   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            r      <= '0;
            c_flag <= 1'b0;
            v_flag <= 1'b0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opReg <= op;
                        aReg  <= a;
                        bReg  <= b;
                        cnt   <= shamt;
                        carry <= 1'b0;
                        busy  <= 1'b1;
                        state <= isShiftOp ? SHIFT : EXEC;
                    end
                end
                EXEC: begin
                    r      <= execR;
                    c_flag <= execC;
                    v_flag <= execV;
                    z_flag <= (execR == '0);
                    n_flag <= execR[WIDTH-1];
                    err    <= execErr;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        r      <= aReg;
                        c_flag <= carry;
                        v_flag <= 1'b0;
                        z_flag <= (aReg == '0);
                        n_flag <= aReg[WIDTH-1];
                        err    <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        aReg  <= shNext;
                        carry <= shOut;
                        cnt   <= cnt - SHW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes model results,
// monitor pops and compares on every done pulse.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] shamt = '0;
    logic       busy, done, cFlag, vFlag, zFlag, nFlag, err;
    logic [7:0] r;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a(a), .b(b), .shamt(shamt),
        .busy(busy), .done(done), .r(r),
        .c_flag(cFlag), .v_flag(vFlag), .z_flag(zFlag),
        .n_flag(nFlag), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    r;
        int    c, v, z, n, e;
        int    cyc;
        string name;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    // Reference model from the arithmetic definitions of each op
    function automatic exp_t model(input int o, input int x,
                                   input int y, input int s);
        exp_t e;
        int t, sv;
        e.r = 0; e.c = 0; e.v = 0; e.e = 0;
        case (o)
            0: begin
                t = x + y; e.r = t % 256; e.c = (t > 255);
                sv = sgn(x) + sgn(y); e.v = (sv > 127 || sv < -128);
            end
            1: begin
                t = x + (255 - y) + 1; e.r = t % 256; e.c = (t > 255);
                sv = sgn(x) - sgn(y); e.v = (sv > 127 || sv < -128);
            end
            2: e.r = x ^ y;
            3: e.r = x & y;
            4: e.r = x | y;
            5: e.r = 255 - (x | y);
            6: begin
                e.r = (x << s) % 256;
                e.c = (s == 0) ? 0 : (x >> (8 - s)) % 2;
            end
            7: begin
                e.r = x >> s;
                e.c = (s == 0) ? 0 : (x >> (s - 1)) % 2;
            end
            8: begin
                e.r = (s == 0) ? x : ((x << s) | (x >> (8 - s))) % 256;
                e.c = (s == 0) ? 0 : e.r % 2;
            end
            9: begin
                e.r = (s == 0) ? x : ((x >> s) | (x << (8 - s))) % 256;
                e.c = (s == 0) ? 0 : e.r / 128;
            end
            default: e.e = 1;
        endcase
        e.z = (e.r == 0);
        e.n = e.r / 128;
        e.cyc = (o >= 6 && o <= 9) ? 1 + s : 1;
        return e;
    endfunction

    task automatic waitIdle();
        int k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) chk("busy timeout", busy, 0);
    endtask

    task automatic issue(input string nm, input int o, input int x,
                         input int y, input int s, input bit push);
        exp_t e;
        waitIdle();
        e = model(o, x, y, s);
        e.cyc = e.cyc + cyc + 1;
        e.name = nm;
        if (push) expQ.push_back(e);
        op = 4'(o); a = 8'(x); b = 8'(y); shamt = 3'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: compare on done, check hold and pulse width otherwise
    initial begin : monitor
        exp_t e;
        logic [7:0] lastR = '0;
        logic [4:0] lastF = '0;
        bit prevDone = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                lastR = '0; lastF = '0; prevDone = 0;
            end else if (done === 1'b1) begin
                if (prevDone) chk("done width", 1, 0);
                if (expQ.size() == 0) begin
                    chk("unexpected done", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    chk({e.name, " r"}, r, e.r);
                    chk({e.name, " c"}, cFlag, e.c);
                    chk({e.name, " v"}, vFlag, e.v);
                    chk({e.name, " z"}, zFlag, e.z);
                    chk({e.name, " n"}, nFlag, e.n);
                    chk({e.name, " err"}, err, e.e);
                    chk({e.name, " cycle"}, cyc, e.cyc);
                    chk({e.name, " busy"}, busy, 0);
                end
                lastR = r;
                lastF = {cFlag, vFlag, zFlag, nFlag, err};
                prevDone = 1;
            end else begin
                chk("hold r", r, lastR);
                chk("hold flags", {cFlag, vFlag, zFlag, nFlag, err}, lastF);
                prevDone = 0;
            end
        end
    end

    initial begin : driver
        int k;
        #1 rst = 1'b1;
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst r", r, 0);
        chk("rst flags", {cFlag, vFlag, zFlag, nFlag, err}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue("add7f01", 0, 8'h7F, 8'h01, 0, 1);
        issue("sub0505", 1, 8'h05, 8'h05, 0, 1);
        issue("sub0001", 1, 8'h00, 8'h01, 0, 1);
        issue("shlC3", 6, 8'hC3, 0, 2, 1);
        issue("rol81", 8, 8'h81, 0, 3, 1);
        issue("ror01", 9, 8'h01, 0, 0, 1);
        issue("shr80", 7, 8'h80, 0, 7, 1);
        op = 4'd0; a = 8'hFF; b = 8'hFF; shamt = 3'd1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        issue("illegal12", 12, 8'h55, 8'hAA, 3, 1);
        issue("xorF0FF", 2, 8'hF0, 8'hFF, 0, 1);

        issue("aborted", 8, 8'hA5, 0, 5, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort r", r, 0);
        chk("abort flags", {cFlag, vFlag, zFlag, nFlag, err}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            issue("rand", int'($urandom_range(15)), int'($urandom_range(255)),
                  int'($urandom_range(255)), int'($urandom_range(7)), 1);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        k = 0;
        while (expQ.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("queue drained", expQ.size(), 0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; power of two, >= 4.
REQ-002 SHALL derive localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-006 SHALL have port op  input  4  operation code, sampled at acceptance.
REQ-007 SHALL have port a  input  WIDTH  operand A, sampled at acceptance.
REQ-008 SHALL have port b  input  WIDTH  operand B, sampled at acceptance.
REQ-009 SHALL have port shamt  input  SHW  shift/rotate count, sampled at acceptance.
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port r  output  WIDTH  registered result.
REQ-013 SHALL have ports c_flag, v_flag, z_flag, n_flag, err  output  1 each  carry, signed overflow, zero, negative, illegal-op.

Function
REQ-014 SHALL decode op: 0 ADD, 1 SUB, 2 XOR, 3 AND, 4 OR, 5 NOR, 6 SHL, 7 SHR (logical), 8 ROL, 9 ROR; 10-15 illegal.
REQ-015 SHALL implement FSM states IDLE, EXEC, SHIFT; IDLE->EXEC on start accepted, non-shift op; IDLE->SHIFT on start accepted, shift/rotate op.
REQ-016 SHALL set busy=1 from the accepting edge N until the completing edge; start while busy=1 is ignored, with no effect on latched operands.
REQ-017 SHALL complete non-shift ops at edge N+1: r, flags, err updated, done=1 for one cycle, busy=0, state IDLE.
REQ-018 SHALL perform shifts/rotates iteratively, one bit position per cycle, completing at edge N+1+shamt; shamt=0 completes at N+1 with r=a, c_flag=0.
REQ-019 SHALL compute SUB as a + ~b + 1, modulo 2^WIDTH; c_flag = carry out (1 = no borrow).
REQ-020 SHALL set c_flag for ADD = carry out; shifts/rotates = last bit shifted/rotated out; logic ops = 0.
REQ-021 SHALL set v_flag = carry into MSB XOR carry out of MSB for ADD/SUB, else 0.
REQ-022 SHALL set z_flag = (r == 0) and n_flag = r[WIDTH-1] for every completed op.
REQ-023 SHALL on illegal op complete at N+1 with r=0, c_flag=0, v_flag=0, z_flag=1, n_flag=0, err=1; err=0 on every legal completion.
REQ-024 SHALL hold r, flags and err unchanged between completions; done=0 except on the completing cycle.
REQ-025 SHALL accept a new start in the cycle after done (back-to-back throughput one op per 2 cycles minimum).

Reset
REQ-026 SHALL on rst=1 immediately force state IDLE, busy=0, done=0, r=0, all flags and err=0, independent of clk.
REQ-027 SHALL abort any in-flight operation on reset; no done pulse for the aborted op; start ignored while rst=1.

Verification (WIDTH=8)
REQ-028 SHALL cover ADD a=0x7F b=0x01 -> edge N+1: r=0x80, v=1, n=1, c=0, z=0, done pulse 1 cycle.
REQ-029 SHALL cover SUB a=0x05 b=0x05 -> r=0x00, z=1, c=1, v=0; SUB a=0x00 b=0x01 -> r=0xFF, c=0, n=1.
REQ-030 SHALL cover SHL a=0xC3 shamt=2 -> done at N+3, r=0x0C, c=1; ROL a=0x81 shamt=3 -> done at N+4, r=0x0C, c=0.
REQ-031 SHALL cover ROR a=0x01 shamt=0 -> done at N+1, r=0x01, c=0; then start asserted during a shamt=7 SHR of a=0x80 -> ignored, r=0x01, done at N+8.
REQ-032 SHALL cover op=12 -> r=0x00, z=1, err=1; following legal XOR a=0xF0 b=0xFF -> r=0x0F, err=0.
REQ-033 SHALL cover rst asserted mid-shift (cycle N+2 of a shamt=5 op) -> busy, done, r, flags, err=0 at once; no done pulse afterwards.
